// File: rtl/ff_pkt_pkg.sv
// Shared types and sizing helpers for the ff_tx frame generator.
// Frame length limits, FSM states and word-count/mod arithmetic.
package ff_pkt_pkg;

  localparam logic [15:0] MIN_LEN     = 16'd60;
  localparam logic [15:0] MAX_LEN     = 16'd1514;
  localparam logic [15:0] ETH_HDR_LEN = 16'd14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DATA,
    GAP,
    DONE
  } state_t;

  typedef struct packed {
    logic [8:0] words;
    logic [1:0] mod;
  } wsz_t;

  function automatic logic [15:0] clamp_len(input logic [15:0] l);
    if (l < MIN_LEN) return MIN_LEN;
    if (l > MAX_LEN) return MAX_LEN;
    return l;
  endfunction

  // mod counts the empty tail bytes of the last word
  function automatic wsz_t frame_size(input logic [15:0] len);
    wsz_t s;
    s.words = 9'((len + 16'd3) >> 2);
    s.mod   = 2'd0 - len[1:0];
    return s;
  endfunction

endpackage

// File: rtl/ff_pkt_word_fmt.sv
// Combinational frame word assembler: big-endian bytes at byte_idx..+3.
// Header is DA, SA, length/type; payload is an incrementing byte ramp.
module ff_pkt_word_fmt
  import ff_pkt_pkg::*;
(
  input  logic [15:0] byte_idx,
  input  logic [15:0] len,
  input  logic [47:0] da,
  input  logic [47:0] sa,
  output logic [31:0] word
);

  function automatic logic [7:0] byte_at(
    input logic [15:0] k,
    input logic [15:0] l,
    input logic [47:0] d,
    input logic [47:0] s
  );
    logic [47:0] sh;
    logic [15:0] ofs;
    logic [15:0] tlen;
    logic [7:0]  b;
    tlen = l - ETH_HDR_LEN;
    b    = 8'h00;
    if (k >= l) begin
      b = 8'h00;
    end else if (k < 16'd6) begin
      sh = d << {k[2:0], 3'b000};
      b  = sh[47:40];
    end else if (k < 16'd12) begin
      ofs = k - 16'd6;
      sh  = s << {ofs[2:0], 3'b000};
      b   = sh[47:40];
    end else if (k == 16'd12) begin
      b = tlen[15:8];
    end else if (k == 16'd13) begin
      b = tlen[7:0];
    end else begin
      ofs = k - ETH_HDR_LEN;
      b   = ofs[7:0];
    end
    return b;
  endfunction

  assign word = {
    byte_at(byte_idx,         len, da, sa),
    byte_at(byte_idx + 16'd1, len, da, sa),
    byte_at(byte_idx + 16'd2, len, da, sa),
    byte_at(byte_idx + 16'd3, len, da, sa)
  };

endmodule

// File: rtl/ff_tx_pkt_gen.sv
// Deterministic Ethernet frame source for the MAC ff_tx_* FIFO port.
// Optional error injection on eop via FF_TX_ERR_INJ_EN.
module ff_tx_pkt_gen
  import ff_pkt_pkg::*;
#(
  parameter logic [47:0] DA         = 48'h0010A47BEA80,
  parameter logic [47:0] SA         = 48'h001234567833,
  parameter int          IFG_CYCLES = 8
) (
  input  logic        Clk_user,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Pkt_len,
  input  logic [15:0] Pkt_num,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Pkt_cnt,
  input  logic        ff_tx_rdy,
  output logic [31:0] ff_tx_data,
  output logic [1:0]  ff_tx_mod,
  output logic        ff_tx_sop,
  output logic        ff_tx_eop,
  output logic        ff_tx_wren,
`ifdef FF_TX_ERR_INJ_EN
  input  logic [7:0]  Err_every,
`endif
  output logic        ff_tx_err
);

  localparam logic [7:0] GAP_END = 8'(IFG_CYCLES - 1);
  localparam bit         NO_GAP  = (IFG_CYCLES == 0);

  state_t      state, nxt;
  logic [15:0] len_q, num_q, bidx;
  logic [8:0]  idx;
  logic [7:0]  gap_cnt;
  logic [31:0] word;
  wsz_t        sz;
  logic        xfer, last, pkt_last;

  assign sz       = frame_size(len_q);
  assign last     = (idx == sz.words - 9'd1);
  assign xfer     = ff_tx_wren && ff_tx_rdy;
  assign pkt_last = ((Pkt_cnt + 16'd1) == num_q);

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (Start) nxt = LOAD;
      LOAD: nxt = (num_q == 16'd0) ? DONE : DATA;
      DATA: begin
        if (xfer && last) begin
          if (pkt_last)    nxt = DONE;
          else if (NO_GAP) nxt = DATA;
          else             nxt = GAP;
        end
      end
      GAP:  if (gap_cnt == GAP_END) nxt = DATA;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      len_q   <= '0;
      num_q   <= '0;
      Pkt_cnt <= '0;
      idx     <= '0;
      bidx    <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == IDLE && Start) begin
        len_q   <= clamp_len(Pkt_len);
        num_q   <= Pkt_num;
        Pkt_cnt <= '0;
      end
      if (state == LOAD) begin
        idx  <= '0;
        bidx <= '0;
      end else if (xfer) begin
        if (last) begin
          idx     <= '0;
          bidx    <= '0;
          Pkt_cnt <= Pkt_cnt + 16'd1;
        end else begin
          idx  <= idx + 9'd1;
          bidx <= bidx + 16'd4;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  ff_pkt_word_fmt u_fmt (
    .byte_idx (bidx),
    .len      (len_q),
    .da       (DA),
    .sa       (SA),
    .word     (word)
  );

  assign Busy       = (state == LOAD) || (state == DATA) || (state == GAP);
  assign Done       = (state == DONE);
  assign ff_tx_wren = (state == DATA);
  assign ff_tx_sop  = ff_tx_wren && (idx == 9'd0);
  assign ff_tx_eop  = ff_tx_wren && last;
  assign ff_tx_mod  = ff_tx_eop ? sz.mod : 2'd0;
  assign ff_tx_data = ff_tx_wren ? word : 32'd0;

`ifdef FF_TX_ERR_INJ_EN
  logic [7:0] err_cnt;
  logic       hit;

  // err_cnt is the 0-based frame index modulo Err_every
  assign hit = (Err_every != 8'd0) && ((err_cnt + 8'd1) == Err_every);

  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      err_cnt <= '0;
    end else if (state == LOAD) begin
      err_cnt <= '0;
    end else if (xfer && last) begin
      err_cnt <= hit ? 8'd0 : err_cnt + 8'd1;
    end
  end

  assign ff_tx_err = ff_tx_eop && hit;
`else
  assign ff_tx_err = 1'b0;
`endif

endmodule

// File: tb/tb_ff_tx_pkt_gen.sv
// Self-checking bench for ff_tx_pkt_gen against a byte-level frame model.
// Error-injection checks are built when FF_TX_ERR_INJ_EN is defined.
module tb_ff_tx_pkt_gen;

  localparam logic [47:0] DA  = 48'h0010A47BEA80;
  localparam logic [47:0] SA  = 48'h001234567833;
  localparam int          IFG = 8;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Pkt_len = '0;
  logic [15:0] Pkt_num = '0;
  logic        Busy, Done;
  logic [15:0] Pkt_cnt;
  logic        rdy = 1'b1;
  logic [31:0] ff_tx_data;
  logic [1:0]  ff_tx_mod;
  logic        ff_tx_sop, ff_tx_eop, ff_tx_wren, ff_tx_err;
`ifdef FF_TX_ERR_INJ_EN
  logic [7:0]  Err_every = '0;
`endif

  ff_tx_pkt_gen #(.DA(DA), .SA(SA), .IFG_CYCLES(IFG)) dut (
    .Clk_user   (clk),
    .Reset      (Reset),
    .Start      (Start),
    .Pkt_len    (Pkt_len),
    .Pkt_num    (Pkt_num),
    .Busy       (Busy),
    .Done       (Done),
    .Pkt_cnt    (Pkt_cnt),
    .ff_tx_rdy  (rdy),
    .ff_tx_data (ff_tx_data),
    .ff_tx_mod  (ff_tx_mod),
    .ff_tx_sop  (ff_tx_sop),
    .ff_tx_eop  (ff_tx_eop),
    .ff_tx_wren (ff_tx_wren),
`ifdef FF_TX_ERR_INJ_EN
    .Err_every  (Err_every),
`endif
    .ff_tx_err  (ff_tx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
    int          cyc;
  } xfer_t;

  xfer_t xq[$];
  int    rise_q[$];
  int    done_q[$];
  int    cyc = 0;
  int    hold_viol = 0;
  int    rdy_mode = 0;
  int    checks = 0;
  int    errors = 0;

  // Monitor: sampled on the falling edge, a word with wren&rdy transfers at the next rise
  initial begin
    logic        pend, pw;
    logic [36:0] hv;
    pend = 1'b0;
    pw   = 1'b0;
    hv   = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend && (!ff_tx_wren ||
          {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err} !== hv))
        hold_viol++;
      pend = ff_tx_wren && !rdy;
      hv   = {ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err};
      if (ff_tx_wren && !pw) rise_q.push_back(cyc);
      pw = ff_tx_wren;
      if (ff_tx_wren && rdy)
        xq.push_back('{ff_tx_data, ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err, cyc});
      if (Done) done_q.push_back(cyc);
    end
  end

  // rdy driver: 0 = always high, 1 = 1,0,0,1 pattern, 2 = random
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       rdy = (ph % 4 == 0) || (ph % 4 == 3);
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      ph++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampf(input int l);
    if (l < 60) return 60;
    if (l > 1514) return 1514;
    return l;
  endfunction

  function automatic logic [7:0] exp_byte(input int len, input int k);
    logic [47:0] t;
    if (k >= len) return 8'h00;
    if (k < 6) begin
      t = DA >> (8 * (5 - k));
      return t[7:0];
    end
    if (k < 12) begin
      t = SA >> (8 * (11 - k));
      return t[7:0];
    end
    if (k == 12) return 8'((len - 14) / 256);
    if (k == 13) return 8'((len - 14) % 256);
    return 8'((k - 14) % 256);
  endfunction

  function automatic logic [31:0] exp_word(input int len, input int w);
    return {exp_byte(len, 4*w), exp_byte(len, 4*w+1),
            exp_byte(len, 4*w+2), exp_byte(len, 4*w+3)};
  endfunction

  function automatic logic [31:0] xd(input int n);
    if (n < xq.size()) return xq[n].d;
    return 'x;
  endfunction

  function automatic logic [1:0] xm(input int n);
    if (n < xq.size()) return xq[n].mod;
    return 'x;
  endfunction

  task automatic clear_mon();
    xq.delete();
    rise_q.delete();
    done_q.delete();
    hold_viol = 0;
  endtask

  task automatic kick(input int len, input int num, output int sc);
    @(posedge clk);
    #1;
    Pkt_len = 16'(len);
    Pkt_num = 16'(num);
    Start   = 1'b1;
    sc      = cyc;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int tail);
    for (int k = 0; k < budget && done_q.size() == 0; k++) @(negedge clk);
    repeat (tail) @(negedge clk);
  endtask

  task automatic run(input string tag, input int len, input int num, output int sc);
    int w;
    w = (clampf(len) + 3) / 4;
    clear_mon();
    kick(len, num, sc);
    check({tag, "_busy_on"}, 64'(Busy), 64'd1);
    wait_done(num * (w + IFG + 2) * 6 + 50, 4);
    check({tag, "_busy_off"}, 64'(Busy), 64'd0);
  endtask

  task automatic verify(input string tag, input int len_in, input int num,
                        input int ev, input int sc, input bit gapchk);
    int L, W, nbad, gbad, n;
    logic [36:0] o, e;
    L = clampf(len_in);
    W = (L + 3) / 4;
    check({tag, "_nxfer"}, 64'(xq.size()), 64'(num * W));
    nbad = 0;
    for (int f = 0; f < num; f++) begin
      for (int i = 0; i < W; i++) begin
        n = f * W + i;
        if (n < xq.size()) begin
          e = {i == 0, i == W - 1,
               (i == W - 1) ? 2'((4 - L % 4) % 4) : 2'd0,
               ev != 0 && i == W - 1 && (f + 1) % ev == 0,
               exp_word(L, i)};
          o = {xq[n].sop, xq[n].eop, xq[n].mod, xq[n].err, xq[n].d};
          if (o !== e) begin
            if (nbad == 0)
              $display("  %s first bad transfer %0d: got %h want %h", tag, n, o, e);
            nbad++;
          end
        end
      end
    end
    check({tag, "_words"}, 64'(nbad), 64'd0);
    check({tag, "_pkt_cnt"}, 64'(Pkt_cnt), 64'(num));
    check({tag, "_done_n"}, 64'(done_q.size()), 64'd1);
    if (num > 0 && done_q.size() > 0 && xq.size() > 0)
      check({tag, "_done_cyc"}, 64'(done_q[0]), 64'(xq[$].cyc + 1));
    if (num > 0 && rise_q.size() > 0)
      check({tag, "_latency"}, 64'(rise_q[0]), 64'(sc + 3));
    if (gapchk && num > 1) begin
      gbad = 0;
      for (int f = 1; f < num; f++) begin
        n = f * W;
        if (n >= xq.size() || xq[n].cyc - xq[n-1].cyc != IFG + 1) gbad++;
      end
      check({tag, "_ifg"}, 64'(gbad), 64'd0);
    end
  endtask

  initial begin
    int sc, len, num, ev, nerr;
    ev = 0;

    repeat (3) @(negedge clk);
    check("rst_wren", 64'(ff_tx_wren), 64'd0);
    check("rst_data", 64'(ff_tx_data), 64'd0);
    check("rst_sop_eop_mod_err", 64'({ff_tx_sop, ff_tx_eop, ff_tx_mod, ff_tx_err}), 64'd0);
    check("rst_busy_done", 64'({Busy, Done}), 64'd0);
    check("rst_pkt_cnt", 64'(Pkt_cnt), 64'd0);
    @(posedge clk);
    #1;
    Reset = 1'b0;

    run("f64", 64, 1, sc);
    verify("f64", 64, 1, ev, sc, 1'b1);
    check("f64_w0", 64'(xd(0)), 64'h0010A47B);
    check("f64_w3", 64'(xd(3)), 64'h00320001);
    check("f64_w15", 64'(xd(15)), 64'h2E2F3031);

    run("f65", 65, 2, sc);
    verify("f65", 65, 2, ev, sc, 1'b1);
    check("f65_w16", 64'(xd(16)), 64'h32000000);
    check("f65_w33", 64'(xd(33)), 64'h32000000);

    run("f20", 20, 1, sc);
    verify("f20", 20, 1, ev, sc, 1'b1);
    check("f20_w3", 64'(xd(3)), 64'h002E0001);

    run("f2000", 2000, 1, sc);
    verify("f2000", 2000, 1, ev, sc, 1'b1);
    check("f2000_mod", 64'(xm(378)), 64'd2);

    rdy_mode = 1;
    run("rdy1001", 64, 1, sc);
    verify("rdy1001", 64, 1, ev, sc, 1'b0);
    check("rdy1001_hold", 64'(hold_viol), 64'd0);
    rdy_mode = 0;

    run("n0", 64, 0, sc);
    verify("n0", 64, 0, ev, sc, 1'b0);
    check("n0_done_cyc", 64'(done_q.size() > 0 ? done_q[0] : -1), 64'(sc + 3));
    check("n0_no_wren", 64'(rise_q.size()), 64'd0);

    // Start while busy must not restart or reconfigure
    clear_mon();
    kick(100, 2, sc);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    Pkt_len = 16'd300;
    Pkt_num = 16'd5;
    Start   = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    wait_done(400, 30);
    verify("busy_start", 100, 2, ev, sc, 1'b1);

    // Asynchronous reset in the middle of the first frame
    clear_mon();
    kick(64, 2, sc);
    for (int k = 0; k < 60 && xq.size() < 8; k++) @(negedge clk);
    check("rst_mid_pre_wren", 64'(ff_tx_wren), 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_mid_wren", 64'(ff_tx_wren), 64'd0);
    check("rst_mid_data", 64'(ff_tx_data), 64'd0);
    check("rst_mid_flags", 64'({ff_tx_sop, ff_tx_eop, Busy, Done}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    Reset = 1'b0;
    run("rst_clean", 64, 1, sc);
    verify("rst_clean", 64, 1, ev, sc, 1'b1);

    for (int it = 0; it < 8; it++) begin
      len      = int'($urandom_range(30, 400));
      num      = int'($urandom_range(1, 3));
      rdy_mode = int'($urandom_range(0, 2));
      run($sformatf("rnd%0d", it), len, num, sc);
      verify($sformatf("rnd%0d", it), len, num, ev, sc, rdy_mode == 0);
      check($sformatf("rnd%0d_hold", it), 64'(hold_viol), 64'd0);
    end
    rdy_mode = 0;

`ifdef FF_TX_ERR_INJ_EN
    ev        = 3;
    Err_every = 8'd3;
    run("err3", 60, 6, sc);
    verify("err3", 60, 6, ev, sc, 1'b1);
    nerr = 0;
    foreach (xq[i]) if (xq[i].err) nerr++;
    check("err3_count", 64'(nerr), 64'd2);
    Err_every = 8'd0;
    ev        = 0;
`else
    nerr = 0;
    foreach (xq[i]) if (xq[i].err) nerr++;
    check("err_tied_off", 64'(nerr), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
